// File: rtl/spi_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cfg_arbiter
//   Registered round-robin arbiter that lends the single shared spi_master to
//   one configuration sequencer (0 = AD9517, 1 = ADC0, 2 = ADC1) for a whole
//   configuration session. It routes chip select to the owning device only,
//   drops and flags commands from anyone who does not own the bus, and
//   enforces an idle chip-select gap between sessions.
//
// Ports
//   clk, rst          system clock (clk_20m), synchronous active-high reset
//   i_req             per-sequencer session request (level, held for session)
//   o_gnt             one-hot grant, registered
//   i_wr_cmd/i_rd_cmd per-sequencer command strobes
//   i_wr_data         packed write words, slice k belongs to sequencer k
//   o_rd_data         read data broadcast from spi_master
//   o_busy            per-sequencer busy (forced high for non-owners)
//   o_drop_err        sticky flag: sequencer issued a command without owning
//   spi_wr_cmd/spi_rd_cmd/spi_wr_data  registered command to spi_master
//   spi_busy, spi_rd_data, spi_ncs     status/data/chip select from spi_master
//   o_cs_n            per-device active-low chip select
// -----------------------------------------------------------------------------
module spi_cfg_arbiter #(
   parameter int unsigned NUM_DEV         = 3,
   parameter int unsigned MOSI_DATA_WIDTH = 24,
   parameter int unsigned MISO_DATA_WIDTH = 8,
   parameter int unsigned GAP_CYCLES      = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_DEV-1:0]                 i_req,
   output logic [NUM_DEV-1:0]                 o_gnt,
   input  logic [NUM_DEV-1:0]                 i_wr_cmd,
   input  logic [NUM_DEV-1:0]                 i_rd_cmd,
   input  logic [NUM_DEV*MOSI_DATA_WIDTH-1:0] i_wr_data,
   output logic [MISO_DATA_WIDTH:0]           o_rd_data,
   output logic [NUM_DEV-1:0]                 o_busy,
   output logic [NUM_DEV-1:0]                 o_drop_err,
   output logic                               spi_wr_cmd,
   output logic                               spi_rd_cmd,
   output logic [MOSI_DATA_WIDTH-1:0]         spi_wr_data,
   input  logic                               spi_busy,
   input  logic [MISO_DATA_WIDTH:0]           spi_rd_data,
   input  logic                               spi_ncs,
   output logic [NUM_DEV-1:0]                 o_cs_n
);

   localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   state_e                       state_q, state_d;
   logic [NUM_DEV-1:0]           gnt_q, gnt_d;
   logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [GAP_W-1:0]             gap_cnt_q, gap_cnt_d;
   logic                         wr_cmd_q, wr_cmd_d;
   logic                         rd_cmd_q, rd_cmd_d;
   logic [MOSI_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [NUM_DEV-1:0]           drop_err_q, drop_err_d;

   logic                         own_wr;
   logic                         own_rd;
   logic [MOSI_DATA_WIDTH-1:0]   own_data;
   logic                         win_found;
   logic [IDX_W-1:0]             win_idx;
   logic [NUM_DEV-1:0]           win_oh;
   logic [IDX_W-1:0]             next_ptr;
   logic [NUM_DEV-1:0]           cmd_any;
   logic [NUM_DEV-1:0]           accept_mask;

   // Select the current owner's command lines (grant is one-hot or zero).
   always_comb begin
      own_wr   = 1'b0;
      own_rd   = 1'b0;
      own_data = '0;
      for (int unsigned k = 0; k < NUM_DEV; k++) begin
         if (gnt_q[k]) begin
            own_wr   = i_wr_cmd[k];
            own_rd   = i_rd_cmd[k];
            own_data = i_wr_data[k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
         end
      end
   end

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 0; i < NUM_DEV; i++) begin
         cand = 32'(rr_ptr_q) + i;
         if (cand >= NUM_DEV) begin
            cand = cand - NUM_DEV;
         end
         if (!win_found && i_req[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   assign win_oh   = NUM_DEV'(1) << win_idx;
   assign next_ptr = (win_idx == IDX_W'(NUM_DEV - 1)) ? '0 : win_idx + IDX_W'(1);

   // Only the owner in OWN may issue; everything else is dropped and flagged.
   assign cmd_any     = i_wr_cmd | i_rd_cmd;
   assign accept_mask = (state_q == ST_OWN) ? gnt_q : '0;

   // Next-state and command register logic.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      gap_cnt_d  = gap_cnt_q;
      wr_cmd_d   = 1'b0;
      rd_cmd_d   = 1'b0;
      wr_data_d  = wr_data_q;
      drop_err_d = drop_err_q | (cmd_any & ~accept_mask);

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d    = win_oh;
               rr_ptr_d = next_ptr;
               state_d  = ST_OWN;
            end
         end
         ST_OWN: begin
            // A simultaneous write and read: the write wins.
            if (own_wr) begin
               wr_cmd_d  = 1'b1;
               wr_data_d = own_data;
            end else if (own_rd) begin
               rd_cmd_d = 1'b1;
            end
            if ((i_req & gnt_q) == '0) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Hold ownership until the last transfer has fully closed.
            if (!spi_busy && spi_ncs) begin
               gnt_d     = '0;
               gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         gap_cnt_q  <= '0;
         wr_cmd_q   <= 1'b0;
         rd_cmd_q   <= 1'b0;
         wr_data_q  <= '0;
         drop_err_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         gap_cnt_q  <= gap_cnt_d;
         wr_cmd_q   <= wr_cmd_d;
         rd_cmd_q   <= rd_cmd_d;
         wr_data_q  <= wr_data_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Chip select and busy pass through for the owner only, with no added
   // latency; grant is clear outside OWN/DRAIN so everything idles high there.
   assign o_cs_n      = ~gnt_q | {NUM_DEV{spi_ncs}};
   assign o_busy      = ~gnt_q | {NUM_DEV{spi_busy}};
   assign o_gnt       = gnt_q;
   assign o_drop_err  = drop_err_q;
   assign o_rd_data   = spi_rd_data;
   assign spi_wr_cmd  = wr_cmd_q;
   assign spi_rd_cmd  = rd_cmd_q;
   assign spi_wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_arbiter
//   Directed bench for spi_cfg_arbiter with a small spi_master model that
//   holds busy for model_len cycles per command, then drops busy (returning
//   read data) and raises chip select one cycle later.
// -----------------------------------------------------------------------------
module tb_spi_cfg_arbiter;

   localparam int unsigned NUM_DEV = 3;
   localparam int unsigned MW      = 24;
   localparam int unsigned RW      = 9;
   localparam int unsigned GAP     = 64;
   localparam int          LIMIT   = 400;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_DEV-1:0]    i_req = '0;
   logic [NUM_DEV-1:0]    o_gnt;
   logic [NUM_DEV-1:0]    i_wr_cmd = '0;
   logic [NUM_DEV-1:0]    i_rd_cmd = '0;
   logic [NUM_DEV*MW-1:0] i_wr_data = '0;
   logic [RW-1:0]         o_rd_data;
   logic [NUM_DEV-1:0]    o_busy;
   logic [NUM_DEV-1:0]    o_drop_err;
   logic                  spi_wr_cmd;
   logic                  spi_rd_cmd;
   logic [MW-1:0]         spi_wr_data;
   logic                  spi_busy = 1'b0;
   logic [RW-1:0]         spi_rd_data = '0;
   logic                  spi_ncs = 1'b1;
   logic [NUM_DEV-1:0]    o_cs_n;

   int n_checks = 0;
   int n_fail   = 0;

   spi_cfg_arbiter #(
      .NUM_DEV(NUM_DEV), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW-1), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt),
      .i_wr_cmd(i_wr_cmd), .i_rd_cmd(i_rd_cmd), .i_wr_data(i_wr_data),
      .o_rd_data(o_rd_data), .o_busy(o_busy), .o_drop_err(o_drop_err),
      .spi_wr_cmd(spi_wr_cmd), .spi_rd_cmd(spi_rd_cmd), .spi_wr_data(spi_wr_data),
      .spi_busy(spi_busy), .spi_rd_data(spi_rd_data), .spi_ncs(spi_ncs),
      .o_cs_n(o_cs_n)
   );

   always #5 clk = ~clk;

   // spi_master model, evaluated on the falling edge.
   int   model_len = 4;
   int   m_cnt     = 0;
   logic m_pend    = 1'b0;
   logic m_is_rd   = 1'b0;
   int   wr_pulses = 0;
   int   rd_pulses = 0;

   always @(negedge clk) begin
      if (rst) begin
         spi_busy    = 1'b0;
         spi_ncs     = 1'b1;
         spi_rd_data = '0;
         m_cnt       = 0;
         m_pend      = 1'b0;
      end else begin
         if (spi_wr_cmd) wr_pulses++;
         if (spi_rd_cmd) rd_pulses++;
         if (m_pend) begin
            spi_ncs = 1'b1;
            m_pend  = 1'b0;
         end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               spi_busy = 1'b0;
               m_pend   = 1'b1;
               if (m_is_rd) spi_rd_data = 9'h1C3;
            end
         end else if (spi_wr_cmd || spi_rd_cmd) begin
            spi_busy = 1'b1;
            spi_ncs  = 1'b0;
            m_cnt    = model_len;
            m_is_rd  = spi_rd_cmd && !spi_wr_cmd;
         end
      end
   end

   // Watch the non-owners during the single-owner session.
   logic mon_t1     = 1'b0;
   logic t1_busy_lo = 1'b0;
   logic t1_cs_lo   = 1'b0;
   logic t1_cs1_lo  = 1'b0;

   always @(negedge clk) begin
      if (mon_t1) begin
         if (!o_busy[0] || !o_busy[2]) t1_busy_lo = 1'b1;
         if (!o_cs_n[0] || !o_cs_n[2]) t1_cs_lo = 1'b1;
         if (!o_cs_n[1]) t1_cs1_lo = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait until the grant is (want_set) non-zero; n returns the ticks taken.
   task automatic wait_gnt(input logic want_set, input string tag, output int n);
      n = 0;
      while (((o_gnt != '0) != want_set) && n < LIMIT) begin
         tick();
         n++;
      end
      chk({tag, "_bound"}, 32'(n < LIMIT), 32'd1);
   endtask

   task automatic wait_owner_idle(input int k, input string tag);
      int n;
      n = 0;
      tick();
      while (o_busy[k] && n < LIMIT) begin
         tick();
         n++;
      end
      chk({tag, "_bound"}, 32'(n < LIMIT), 32'd1);
   endtask

   int          n;
   int          own;
   int          wr_before;
   int          bad;
   int          held;
   logic [2:0]  exp_g;

   initial begin
      // ---------------- reset values ----------------
      repeat (3) tick();
      chk("rst_gnt",      32'(o_gnt), 32'h0);
      chk("rst_cs_n",     32'(o_cs_n), 32'h7);
      chk("rst_busy",     32'(o_busy), 32'h7);
      chk("rst_drop_err", 32'(o_drop_err), 32'h0);
      chk("rst_spi_cmd",  32'({spi_wr_cmd, spi_rd_cmd}), 32'h0);
      chk("rst_spi_data", 32'(spi_wr_data), 32'h0);
      rst = 1'b0;

      // ---------------- single owner ----------------
      mon_t1 = 1'b1;
      i_req  = 3'b010;
      tick();
      chk("t1_gnt", 32'(o_gnt), 32'h2);
      i_wr_cmd = 3'b010;
      i_wr_data[1*MW +: MW] = 24'h000A5F;
      tick();
      i_wr_cmd = '0;
      chk("t1_spi_wr",   32'(spi_wr_cmd), 32'h1);
      chk("t1_spi_rd",   32'(spi_rd_cmd), 32'h0);
      chk("t1_spi_data", 32'(spi_wr_data), 32'h000A5F);
      tick();
      chk("t1_strobe_width", 32'(spi_wr_cmd), 32'h0);
      chk("t1_cs_n",  32'(o_cs_n), 32'h5);
      chk("t1_busy",  32'(o_busy), 32'h7);
      wait_owner_idle(1, "t1_idle");
      // write and read together: write wins
      i_wr_cmd = 3'b010;
      i_rd_cmd = 3'b010;
      i_wr_data[1*MW +: MW] = 24'h123456;
      tick();
      i_wr_cmd = '0;
      i_rd_cmd = '0;
      chk("t1_both_wr",   32'(spi_wr_cmd), 32'h1);
      chk("t1_both_rd",   32'(spi_rd_cmd), 32'h0);
      chk("t1_both_data", 32'(spi_wr_data), 32'h123456);
      chk("t1_both_drop", 32'(o_drop_err), 32'h0);
      wait_owner_idle(1, "t1_idle2");
      i_req = '0;
      wait_gnt(1'b0, "t1_release", n);
      mon_t1 = 1'b0;
      chk("t1_others_busy", 32'(t1_busy_lo), 32'h0);
      chk("t1_others_cs",   32'(t1_cs_lo), 32'h0);
      chk("t1_cs1_toggled", 32'(t1_cs1_lo), 32'h1);

      // ---------------- round robin ----------------
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_req = 3'b111;
      for (int s = 0; s < 4; s++) begin
         own   = s % 3;
         exp_g = 3'(1 << own);
         wait_gnt(1'b1, "rr_grant", n);
         chk($sformatf("rr_order%0d", s), 32'(o_gnt), 32'(exp_g));
         if (s > 0) chk($sformatf("rr_gap%0d", s), 32'(n), 32'(GAP + 1));
         if (s == 3) break;
         i_wr_cmd = exp_g;
         i_wr_data[own*MW +: MW] = 24'h100000 + 24'(s);
         tick();
         i_wr_cmd = '0;
         chk($sformatf("rr_data%0d", s), 32'(spi_wr_data), 32'h100000 + 32'(s));
         wait_owner_idle(own, "rr_idle");
         i_req = i_req & ~exp_g;
         wait_gnt(1'b0, "rr_release", n);
         chk($sformatf("rr_cs_idle%0d", s), 32'(o_cs_n), 32'h7);
         i_req = 3'b111;
      end

      // ---------------- drain (owner 0 from the 4th grant) ----------------
      model_len = 20;
      i_wr_cmd  = 3'b001;
      tick();
      i_wr_cmd = '0;
      tick();
      chk("dr_pre_busy", 32'(o_busy[0]), 32'h1);
      i_req = 3'b110;
      tick();
      chk("dr_gnt_held", 32'(o_gnt), 32'h1);
      chk("dr_cs_held",  32'(o_cs_n), 32'h6);
      i_wr_cmd = 3'b001;
      tick();
      i_wr_cmd = '0;
      chk("dr_cmd_blocked", 32'(spi_wr_cmd), 32'h0);
      chk("dr_cmd_flag",    32'(o_drop_err), 32'h1);
      bad  = 0;
      held = 0;
      n    = 0;
      while (o_gnt != '0 && n < LIMIT) begin
         if (o_gnt != 3'b001) bad++;
         if (!spi_busy && spi_ncs) held++;
         tick();
         n++;
      end
      chk("dr_bound",      32'(n < LIMIT), 32'h1);
      chk("dr_gnt_stable", 32'(bad), 32'h0);
      chk("dr_no_linger",  32'(held), 32'h0);
      chk("dr_exit_busy",  32'(spi_busy), 32'h0);
      chk("dr_exit_ncs",   32'(spi_ncs), 32'h1);
      chk("dr_exit_cs_n",  32'(o_cs_n), 32'h7);

      // ---------------- illegal command ----------------
      model_len = 4;
      i_req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_req = 3'b001;
      tick();
      chk("il_gnt", 32'(o_gnt), 32'h1);
      wr_before = wr_pulses;
      i_wr_cmd = 3'b100;
      i_wr_data[2*MW +: MW] = 24'hFFFFFF;
      tick();
      i_wr_cmd = '0;
      chk("il_no_spi_wr", 32'(spi_wr_cmd), 32'h0);
      chk("il_drop_err",  32'(o_drop_err), 32'h4);
      tick();
      chk("il_no_pulse", 32'(wr_pulses - wr_before), 32'h0);
      i_req = '0;
      wait_gnt(1'b0, "il_release", n);
      i_req = 3'b010;
      wait_gnt(1'b1, "il_grant1", n);
      chk("il_gnt1", 32'(o_gnt), 32'h2);

      // ---------------- read path (owner 1) ----------------
      i_rd_cmd = 3'b010;
      tick();
      i_rd_cmd = '0;
      chk("rd_spi_rd", 32'(spi_rd_cmd), 32'h1);
      chk("rd_spi_wr", 32'(spi_wr_cmd), 32'h0);
      wait_owner_idle(1, "rd_idle");
      chk("rd_data", 32'(o_rd_data), 32'h1C3);
      i_req = '0;
      wait_gnt(1'b0, "rd_release", n);
      chk("il_drop_sticky", 32'(o_drop_err), 32'h4);

      // ---------------- reset mid-session ----------------
      i_req = 3'b010;
      wait_gnt(1'b1, "mr_grant", n);
      chk("mr_gnt", 32'(o_gnt), 32'h2);
      i_wr_cmd = 3'b010;
      tick();
      i_wr_cmd = '0;
      tick();
      chk("mr_pre_busy", 32'(spi_busy), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_gnt_clr",  32'(o_gnt), 32'h0);
      chk("mr_cs_n",     32'(o_cs_n), 32'h7);
      chk("mr_busy",     32'(o_busy), 32'h7);
      chk("mr_drop_clr", 32'(o_drop_err), 32'h0);
      chk("mr_spi_cmd",  32'({spi_wr_cmd, spi_rd_cmd}), 32'h0);
      i_req = 3'b111;
      tick();
      chk("mr_first_dev0", 32'(o_gnt), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

- Sits between the device configuration sequencers (AD9517 clock chip, ADC0, ADC1) and the single shared `spi_master`.
- Replaces the combinational priority mux with a registered round-robin arbiter that grants the SPI bus to one sequencer for the whole of its configuration session.
- Routes the master's chip select only to the owning device and drops commands from non-owners.
- Enforces a chip-select gap between sessions.

## Interface
Parameters:
- `NUM_DEV`, 3: number of requesting sequencers/devices; index 0 = AD9517, 1 = ADC0, 2 = ADC1.
- `MOSI_DATA_WIDTH`, 24: width of one write word.
- `MISO_DATA_WIDTH`, 8: read data is `MISO_DATA_WIDTH+1` bits, matching `spi_master`.
- `GAP_CYCLES`, 64: minimum idle `clk` cycles between one session's end and the next grant; equals one `spi_clk` period.

Ports:
- `clk`  in  1  system clock (clk_20m domain).
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  NUM_DEV  per-sequencer session request. Level, held high for the whole session.
- `o_gnt`  out  NUM_DEV  one-hot grant; at most one bit set.
- `i_wr_cmd`  in  NUM_DEV  per-sequencer write strobe.
- `i_rd_cmd`  in  NUM_DEV  per-sequencer read strobe.
- `i_wr_data`  in  NUM_DEV*MOSI_DATA_WIDTH  packed write words; sequencer k uses slice k.
- `o_rd_data`  out  MISO_DATA_WIDTH+1  read data broadcast to all sequencers.
- `o_busy`  out  NUM_DEV  per-sequencer busy.
- `o_drop_err`  out  NUM_DEV  sticky flag: a command arrived while that sequencer was not granted.
- `spi_wr_cmd`  out  1  to `spi_master`.
- `spi_rd_cmd`  out  1  to `spi_master`.
- `spi_wr_data`  out  MOSI_DATA_WIDTH  to `spi_master`.
- `spi_busy`  in  1  from `spi_master`.
- `spi_rd_data`  in  MISO_DATA_WIDTH+1  from `spi_master`.
- `spi_ncs`  in  1  chip select driven by `spi_master`.
- `o_cs_n`  out  NUM_DEV  per-device chip select, active low.

## Operation
State machine has four states: IDLE, OWN, DRAIN, GAP.

- **IDLE**
  - Any `i_req` bit high → pick the winner round-robin, starting from the index after the last owner (index 0 first after reset).
  - Register `o_gnt` one-hot; go to OWN.
- **OWN**
  - Owner's `i_wr_cmd`/`i_rd_cmd`/`i_wr_data` are registered onto `spi_*`.
  - `o_cs_n[owner] = spi_ncs`; all other `o_cs_n` bits = 1.
  - Owner's `i_req` falls → go to DRAIN.
- **DRAIN**
  - Accept no new commands; `spi_wr_cmd`/`spi_rd_cmd` = 0.
  - CS routing is held.
  - When `spi_busy`=0 and `spi_ncs`=1: clear `o_gnt`, load the gap counter with GAP_CYCLES-1, go to GAP.
- **GAP**
  - All `o_cs_n` = 1.
  - Counter decrements each cycle; at 0 go to IDLE.
- **Busy**
  - `o_busy[k] = spi_busy` when k owns the bus.
  - Otherwise `o_busy[k] = 1`, so non-owners never issue.
- **Command filtering**
  - `wr_cmd` and `rd_cmd` both high from the owner in one cycle: the write wins, the read is discarded.
  - Command from a non-owner, or from the owner in DRAIN/GAP: discarded and `o_drop_err[k]` set. The flag clears only on `rst`.
- **Read data:** `o_rd_data` is wired straight from `spi_rd_data`; sequencers qualify it with their own busy falling edge.
- **Reset mid-session**
  - All state returns to reset values on the next edge, including the gap counter and round-robin pointer.
  - Reset does not wait for `spi_busy`; `spi_master` is reset by the same reset.

## Timing
- Reset values:
  - `o_gnt`=0, `o_cs_n`=all 1, `o_busy`=all 1, `o_drop_err`=0.
  - `spi_wr_cmd`=`spi_rd_cmd`=0, `spi_wr_data`=0.
  - State IDLE, round-robin pointer = 0.
- Request to grant: `i_req` high at edge N gives `o_gnt` high after edge N+1.
- Command latency: owner strobe at edge N gives a `spi_*` strobe after edge N+1, one cycle wide, data aligned.
- `o_cs_n` and `o_busy` follow `spi_ncs`/`spi_busy` combinationally from registered ownership; zero added latency.
- Request drop to next grant: at least (drain time) + GAP_CYCLES + 1 cycles.
- Simultaneous requests are resolved in a single cycle. A request arriving during DRAIN/GAP waits for IDLE.

## Test plan
- **Single owner:** reset; raise `i_req`=3'b010; issue `i_wr_cmd[1]` with data 0x000A5F.
  - `o_gnt`=3'b010 one cycle after the request.
  - `spi_wr_data`=0x000A5F one cycle after the strobe.
  - Only `o_cs_n[1]` toggles; `o_busy[0]`=`o_busy[2]`=1 throughout.
- **Round robin:** hold `i_req`=3'b111; each owner drops its request after one write.
  - Grant order is 0, 1, 2, 0.
  - At least 64 cycles with all `o_cs_n`=1 between sessions.
- **Drain:** owner drops `i_req` while `spi_busy`=1.
  - `o_gnt` is held until `spi_busy`=0 and `spi_ncs`=1.
  - GAP is entered only after both conditions.
- **Illegal command:** owner=0; pulse `i_wr_cmd[2]`.
  - No `spi_wr_cmd` pulse.
  - `o_drop_err`=3'b100, and it remains set after further sessions.
- **Read path:** owner 1 issues `rd_cmd`; the `spi_master` model returns 0x1C3.
  - `o_rd_data`=0x1C3 when `o_busy[1]` falls.
- **Reset mid-session:** assert `rst` for one cycle during OWN with `spi_busy`=1.
  - Next cycle: `o_gnt`=0, `o_cs_n`=3'b111, state IDLE.
  - A new request is granted to device 0 first.
